// File: rtl/btn_pulse_gen.sv
// Push-button debouncer emitting a one-cycle d_pulse on each qualified press (and on each release when RELEASE_PULSE_EN is defined).
// Latency: the 2-flop sync plus STABLE_CYCLES samples, so level_out/d_pulse rise on edge 2+STABLE_CYCLES of a stable level.
// Backpressure: none; btn_in is sampled every cycle and d_pulse is a fire-and-forget strobe.
module btn_pulse_gen #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic d_pulse,
    output logic level_out,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

`ifdef RELEASE_PULSE_EN
    localparam logic REL_PULSE = 1'b1;
`else
    localparam logic REL_PULSE = 1'b0;
`endif

    logic             sync_q1;
    logic             sync_q2;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_in;
            sync_q2 <= sync_q1;
        end
    end

    // The first differing sample already counts as 1, so acceptance happens
    // on the edge where the counter would reach STABLE_CYCLES.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE_LOW;
            cnt       <= '0;
            level_out <= 1'b0;
            d_pulse   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            d_pulse <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    level_out <= 1'b0;
                    if (sync_q2) begin
                        state <= WAIT_HIGH;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end else begin
                        cnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync_q2) begin
                        state     <= IDLE_LOW;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        level_out <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE_HIGH;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        level_out <= 1'b1;
                        d_pulse   <= 1'b1;
                    end else begin
                        cnt       <= cnt + CNT_ONE;
                        busy      <= 1'b1;
                        level_out <= 1'b0;
                    end
                end
                IDLE_HIGH: begin
                    level_out <= 1'b1;
                    if (!sync_q2) begin
                        state <= WAIT_LOW;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end else begin
                        cnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                WAIT_LOW: begin
                    if (sync_q2) begin
                        state     <= IDLE_HIGH;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        level_out <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE_LOW;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        level_out <= 1'b0;
                        d_pulse   <= REL_PULSE;
                    end else begin
                        cnt       <= cnt + CNT_ONE;
                        busy      <= 1'b1;
                        level_out <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE_LOW;
                    cnt       <= '0;
                    busy      <= 1'b0;
                    level_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/btn_pulse_gen.md
BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: number of consecutive synchronized samples of a new input level required before it is accepted; legal range 2..255.
REQ-002 Parameter CNT_W, default 8: stability counter width; SHALL satisfy STABLE_CYCLES < 2**CNT_W.
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port btn_in  input  1  raw, asynchronous, bouncing push-button level.
REQ-006 Port d_pulse  output  1  registered single-cycle pulse; this is the d input of the downstream state-toggle FSM.
REQ-007 Port level_out  output  1  registered debounced button level.
REQ-008 Port busy  output  1  high while a candidate level change is being qualified.

Function
REQ-009 btn_in SHALL pass through a two-flop synchronizer; no other logic SHALL read btn_in directly.
REQ-010 FSM states SHALL be IDLE_LOW, WAIT_HIGH, IDLE_HIGH and WAIT_LOW.
REQ-011 IDLE_LOW: if synced input is 1, go to WAIT_HIGH with counter = 1; otherwise hold with counter = 0.
REQ-012 WAIT_HIGH: if synced input is 1, increment the counter; when the counter reaches STABLE_CYCLES, go to IDLE_HIGH and clear the counter.
REQ-013 WAIT_HIGH: if synced input is 0 (glitch), return to IDLE_LOW and clear the counter.
REQ-014 IDLE_HIGH and WAIT_LOW SHALL mirror REQ-011 to REQ-013 with levels inverted.
REQ-015 level_out SHALL be 1 in IDLE_HIGH and WAIT_LOW, and 0 otherwise; it SHALL be registered.
REQ-016 Latency: with btn_in stable high from before clock edge 1 in IDLE_LOW, level_out SHALL rise on edge 2+STABLE_CYCLES.
REQ-017 d_pulse SHALL be 1 for exactly the one cycle following the edge on which level_out rises; it SHALL be 0 in every other cycle (falling behaviour per REQ-024/025).
REQ-018 busy SHALL be 1 in WAIT_HIGH and WAIT_LOW, and 0 otherwise.
REQ-019 The counter SHALL never exceed STABLE_CYCLES and SHALL never wrap.
REQ-020 Any bounce shorter than STABLE_CYCLES consecutive samples SHALL produce no change on level_out and no d_pulse.
REQ-021 An unreachable state encoding SHALL recover to IDLE_LOW on the next edge with all outputs 0.

Reset
REQ-022 Asserting reset at any time, including mid-WAIT_*, SHALL immediately force: state IDLE_LOW, counter 0, synchronizer flops 0, level_out 0, d_pulse 0, busy 0.
REQ-023 After reset deasserts, a button already held high SHALL be qualified as a fresh press and produce one d_pulse per REQ-016/017.

Configuration
REQ-024 With RELEASE_PULSE_EN defined, d_pulse SHALL also assert for exactly one cycle following the edge on which level_out falls.
REQ-025 Without RELEASE_PULSE_EN, d_pulse SHALL assert only on debounced rising transitions; level_out and busy are identical in both builds.

Verification
REQ-026 STABLE_CYCLES=4; btn_in high from before edge 1 -> level_out=1 after edge 6; d_pulse=1 only between edges 6 and 7; busy=1 from edge 3 to edge 6.
REQ-027 STABLE_CYCLES=4; btn_in high 3 cycles, low 1, high 3, then low -> level_out stays 0; d_pulse never asserts.
REQ-028 STABLE_CYCLES=4; press as in REQ-026, then release with a stable low -> level_out falls 6 edges after the release; d_pulse=1 for one cycle only if RELEASE_PULSE_EN is defined, else it stays 0.
REQ-029 Reset asserted mid-WAIT_HIGH while the counter is 2 -> all outputs 0 immediately; with btn_in held high after release, exactly one d_pulse follows at edge 2+STABLE_CYCLES.
REQ-030 Ten qualified press/release cycles fed into the downstream toggle FSM -> exactly ten d_pulses (twenty with RELEASE_PULSE_EN), each one cycle wide.
